// File: rtl/io_input_conditioner.sv
// io_input_conditioner
// Pad-side input conditioning for the DM interface. Each channel is
// optionally inverted, synchronised into the clk domain and passed through
// a counter-based glitch filter. The result is the level y, with
// single-cycle rise/fall pulses, sticky per-channel edge flags and a global
// change strobe.
module io_input_conditioner #(
  parameter int               WIDTH       = 9,
  parameter int               SYNC_STAGES = 2,
  parameter int               FILTER_LEN  = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] INVERT_MASK = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pad_in,
  input  logic             filt_en,
  input  logic [WIDTH-1:0] clr_latched,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] edge_latched,
  output logic             any_change
);

  // The counter only has to reach FILTER_LEN-1; keep at least one bit.
  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_LEN - 1);
  localparam logic [WIDTH-1:0] SYNC_RST  = RESET_VALUE ^ INVERT_MASK;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [CNT_W-1:0] last_cnt;
  logic [WIDTH-1:0] y_next;
  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_next;
  logic [WIDTH-1:0] latched_next;

  assign s = sync_q[SYNC_STAGES-1];

  // Bypass behaves exactly like a filter of length one.
  assign last_cnt = filt_en ? FILT_LAST : '0;

  // Synchroniser chain on the (optionally inverted) raw pads.
  // NOTE: every synchroniser stage is reset so s is defined from the first
  // cycle after release; without it the filter would compare against X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
    end else begin
      sync_q[0] <= pad_in ^ INVERT_MASK;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Per-channel filter decision and edge / flag next-state.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    y_next = y;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (s[i] != y[i]) begin
        // >= rather than == so a count left over from filtered mode is
        // accepted immediately once the filter is bypassed.
        if (cnt[i] >= last_cnt) begin
          y_next[i] = s[i];
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
    rise_next    = y_next & ~y;
    fall_next    = ~y_next & y;
    // A new edge wins over a simultaneous clear, so no event is lost.
    latched_next = (edge_latched & ~clr_latched) | rise_next | fall_next;
  end

  // Register level, counters, pulses and flags together in one stage.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y            <= RESET_VALUE;
      rise         <= '0;
      fall         <= '0;
      edge_latched <= '0;
      any_change   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      y            <= y_next;
      rise         <= rise_next;
      fall         <= fall_next;
      edge_latched <= latched_next;
      any_change   <= |(rise_next | fall_next);
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
    end
  end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner: default instance plus an
// inverted-channel instance (INVERT_MASK = RESET_VALUE = 9'h100).
module tb_io_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] pad_in;
  logic       filt_en;
  logic [8:0] clr_latched;
  logic [8:0] y, rise, fall, edge_latched;
  logic       any_change;

  logic [8:0] pad_inv;
  logic [8:0] clr_inv;
  logic [8:0] y_inv, rise_inv, fall_inv, latched_inv;
  logic       any_inv;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  io_input_conditioner dut (
    .clk(clk), .rst(rst), .pad_in(pad_in), .filt_en(filt_en),
    .clr_latched(clr_latched), .y(y), .rise(rise), .fall(fall),
    .edge_latched(edge_latched), .any_change(any_change)
  );

  io_input_conditioner #(
    .WIDTH(9), .SYNC_STAGES(2), .FILTER_LEN(4),
    .RESET_VALUE(9'h100), .INVERT_MASK(9'h100)
  ) dut_inv (
    .clk(clk), .rst(rst), .pad_in(pad_inv), .filt_en(filt_en),
    .clr_latched(clr_inv), .y(y_inv), .rise(rise_inv), .fall(fall_inv),
    .edge_latched(latched_inv), .any_change(any_inv)
  );

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; pad_in = '0; pad_inv = '0; filt_en = 1'b1;
    clr_latched = '0; clr_inv = '0;
    tick(); tick();
    check("rst_y", y, 9'h000);
    check("rst_rise_fall", rise | fall, 9'h000);
    check("rst_latched", edge_latched, 9'h000);
    check("rst_any", any_change, 1'b0);
    check("rst_inv_y", y_inv, 9'h100);
    rst = 1'b0;
    tick(); tick();

    // 1: filtered rise on channel 0; inverted instance must stay quiet.
    pad_in[0] = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check("t1_y_wait", y, 9'h000);
      check("t1_any_wait", any_change, 1'b0);
      check("t5_inv_hold", y_inv, 9'h100);
      check("t5_inv_noedge", rise_inv | fall_inv, 9'h000);
    end
    tick();
    check("t1_y_e6", y, 9'h001);
    check("t1_rise_e6", rise, 9'h001);
    check("t1_any_e6", any_change, 1'b1);
    check("t1_latched", edge_latched, 9'h001);
    tick();
    check("t1_rise_off", rise, 9'h000);
    check("t1_any_off", any_change, 1'b0);
    check("t1_y_hold", y, 9'h001);

    // 5: inverted channel, pad 0->1 gives a fall at edge 6.
    pad_inv[8] = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check("t5_y_wait", y_inv, 9'h100);
    end
    tick();
    check("t5_y_e6", y_inv, 9'h000);
    check("t5_fall_e6", fall_inv, 9'h100);
    check("t5_rise_e6", rise_inv, 9'h000);
    check("t5_latched", latched_inv, 9'h100);

    // Clear channel 0 flag before the glitch test.
    clr_latched = 9'h001;
    tick();
    clr_latched = '0;
    check("clr0", edge_latched, 9'h000);

    // 2: 3-cycle glitch on channel 3, filtered: rejected.
    pad_in[3] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 3) pad_in[3] = 1'b0;
      check("t2_y", y, 9'h001);
      check("t2_edges", rise | fall, 9'h000);
      check("t2_latched", edge_latched, 9'h000);
    end

    // 3: same glitch bypassed: high after edges 3,4,5.
    filt_en = 1'b0;
    pad_in[3] = 1'b1;
    tick(); check("t3_y_e1", y, 9'h001);
    tick(); check("t3_y_e2", y, 9'h001);
    tick(); check("t3_y_e3", y, 9'h009);
    check("t3_rise_e3", rise, 9'h008);
    check("t3_any_e3", any_change, 1'b1);
    pad_in[3] = 1'b0;
    tick(); check("t3_y_e4", y, 9'h009);
    check("t3_rise_e4", rise, 9'h000);
    tick(); check("t3_y_e5", y, 9'h009);
    tick(); check("t3_y_e6", y, 9'h001);
    check("t3_fall_e6", fall, 9'h008);
    check("t3_latched", edge_latched, 9'h008);
    tick(); check("t3_fall_off", fall, 9'h000);

    // 4: set wins over simultaneous clear on channel 5.
    pad_in[5] = 1'b1;
    tick(); tick(); tick();
    check("t4_rise5", rise, 9'h020);
    check("t4_latched_set", edge_latched, 9'h028);
    pad_in[5] = 1'b0;
    tick(); tick();
    clr_latched = 9'h020;
    tick();
    check("t4_fall5", fall, 9'h020);
    check("t4_set_wins", edge_latched, 9'h028);
    clr_latched = '0;
    tick();
    check("t4_hold", edge_latched, 9'h028);
    clr_latched = 9'h020;
    tick();
    check("t4_lone_clr", edge_latched, 9'h008);
    clr_latched = 9'h1ff;
    tick();
    check("t4_clr_all", edge_latched, 9'h000);
    clr_latched = '0;

    // 6: reset mid-count on channel 1, release with pads high.
    filt_en = 1'b1;
    pad_in[1] = 1'b1;
    tick(); tick(); tick(); tick();
    check("t6_y_pre", y, 9'h001);
    rst = 1'b1;
    #2;
    check("t6_rst_y", y, 9'h000);
    check("t6_rst_edges", rise | fall, 9'h000);
    check("t6_rst_latched", edge_latched, 9'h000);
    check("t6_rst_any", any_change, 1'b0);
    tick(); tick();
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check("t6_y_wait", y, 9'h000);
    end
    tick();
    check("t6_y_e6", y, 9'h003);
    check("t6_rise_e6", rise, 9'h003);
    check("t6_any_e6", any_change, 1'b1);
    check("t6_latched", edge_latched, 9'h003);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
